ps2_kbd_tx: RTL and testbench

- Device-side PS/2 keyboard transmitter; the producing end of the scancode stream our keyboard display FSM consumes.
- Accepts key events (code + press/release), expands each into a scancode byte sequence (make: code; break: F0, code), and serializes each byte as an 11-bit PS/2 frame on ps2_clk/ps2_data.
- Used as the keyboard model in simulation and as a loopback source on the board.

---
 rtl/ps2_pkg.sv | 41 ++++
 rtl/ps2_kbd_tx_if.sv | 36 +++
 rtl/ps2_frame_ser.sv | 98 +++++++++
 rtl/ps2_kbd_tx.sv | 136 +++++++++++++
 tb/tb_ps2_kbd_tx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and frame helpers for the PS/2 keyboard transmitter.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam int unsigned PS2_FRAME_BITS  = 11;

    // One-hot serializer phases
    typedef enum logic [3:0] {
        StIdle = 4'b0001,
        StHi   = 4'b0010,
        StLo   = 4'b0100,
        StGap  = 4'b1000
    } ps2_state_e;

    // One-hot event sequencer states
    typedef enum logic [3:0] {
        KbdIdle  = 4'b0001,
        KbdLoad  = 4'b0010,
        KbdFrame = 4'b0100,
        KbdGap   = 4'b1000
    } kbd_state_e;

    // Bit i is the i-th bit on the wire: start, data LSB first, odd parity, stop.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // Byte at position idx of an event whose last position is last.
    function automatic logic [7:0] ps2_seq_byte(input logic [1:0] idx, input logic [1:0] last,
                                                input logic ext, input logic [7:0] code);
        if (idx == last) begin
            return code;
        end
        if (ext && (idx == 2'd0)) begin
            return PS2_EXT_PREFIX;
        end
        return PS2_BREAK_PREFIX;
    endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Key-event handshake and PS/2 line bundle; key_ext exists only with PS2_KBD_TX_EXT_EN.
interface ps2_kbd_tx_if;

    logic       key_valid;
    logic [7:0] key_code;
    logic       key_release;
`ifdef PS2_KBD_TX_EXT_EN
    logic       key_ext;
`endif
    logic       key_ready;
    logic       busy;
    logic       ps2_clk;
    logic       ps2_data;
    logic       byte_sent;

`ifdef PS2_KBD_TX_EXT_EN
    modport master (
        output key_valid, key_code, key_release, key_ext,
        input  key_ready, busy, ps2_clk, ps2_data, byte_sent
    );
    modport slave (
        input  key_valid, key_code, key_release, key_ext,
        output key_ready, busy, ps2_clk, ps2_data, byte_sent
    );
`else
    modport master (
        output key_valid, key_code, key_release,
        input  key_ready, busy, ps2_clk, ps2_data, byte_sent
    );
    modport slave (
        input  key_valid, key_code, key_release,
        output key_ready, busy, ps2_clk, ps2_data, byte_sent
    );
`endif

endinterface

// File: rtl/ps2_frame_ser.sv
// Serializes one byte as an 11-bit PS/2 frame; each half-period lasts CLK_DIV clocks.
module ps2_frame_ser
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       byte_sent
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [3:0]                  bit_idx_q, bit_idx_d;
    logic [PS2_FRAME_BITS-1:0]   frame_q, frame_d;
    logic                        data_q, data_d;
    logic [PS2_FRAME_BITS-1:0]   new_frame;

    assign new_frame = ps2_frame(data);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        data_d    = data_q;
        byte_sent = 1'b0;
        unique case (state_q)
            StIdle: begin
                data_d = 1'b1;
                if (start) begin
                    state_d   = StHi;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    frame_d   = new_frame;
                    data_d    = new_frame[0];
                end
            end
            StHi: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = StLo;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLo: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d   = StIdle;
                        byte_sent = 1'b1;
                        data_d    = 1'b1;
                    end else begin
                        state_d   = StHi;
                        bit_idx_d = bit_idx_q + 4'd1;
                        // Data changes only on entry to the high phase
                        data_d    = frame_q[bit_idx_q + 4'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                data_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            frame_q   <= '0;
            data_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            data_q    <= data_d;
        end
    end

    assign ps2_clk  = (state_q != StLo);
    assign ps2_data = data_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard transmitter: latches key events and sends make/break scancode frames.
// Define PS2_KBD_TX_EXT_EN to add key_ext and the E0 extended-key prefix.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned GAP_HALVES = 4
) (
    input logic         clk,
    input logic         rst,
    ps2_kbd_tx_if.slave bus
);

`ifdef PS2_KBD_TX_EXT_EN
    localparam int unsigned BIDX_W = 2;
`else
    localparam int unsigned BIDX_W = 1;
`endif
    localparam int unsigned GAP_CYC = GAP_HALVES * CLK_DIV;
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    kbd_state_e        state_q, state_d;
    logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]        code_q;
    logic              rel_q;
    logic              ext_en;
    logic              accept;
    logic              start;
    logic              frame_done;
    logic [BIDX_W-1:0] last_idx;
    logic [7:0]        tx_byte;
    logic              ser_clk;
    logic              ser_data;

    assign accept   = (state_q == KbdIdle) && bus.key_valid;
    assign last_idx = BIDX_W'(rel_q) + BIDX_W'(ext_en);
    assign tx_byte  = ps2_seq_byte(2'(byte_idx_d), 2'(last_idx), ext_en, code_q);

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        start      = 1'b0;
        unique case (state_q)
            KbdIdle: begin
                if (bus.key_valid) begin
                    state_d    = KbdLoad;
                    byte_idx_d = '0;
                end
            end
            // Separate load cycle so the latched event is stable when the serializer starts
            KbdLoad: begin
                start   = 1'b1;
                state_d = KbdFrame;
            end
            KbdFrame: begin
                if (frame_done) begin
                    state_d   = KbdGap;
                    gap_cnt_d = '0;
                end
            end
            KbdGap: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (byte_idx_q == last_idx) begin
                        state_d = KbdIdle;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        start      = 1'b1;
                        state_d    = KbdFrame;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = KbdIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= KbdIdle;
            byte_idx_q <= '0;
            gap_cnt_q  <= '0;
            code_q     <= '0;
            rel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            if (accept) begin
                code_q <= bus.key_code;
                rel_q  <= bus.key_release;
            end
        end
    end

`ifdef PS2_KBD_TX_EXT_EN
    logic ext_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_q <= 1'b0;
        end else if (accept) begin
            ext_q <= bus.key_ext;
        end
    end

    assign ext_en = ext_q;
`else
    assign ext_en = 1'b0;
`endif

    ps2_frame_ser #(
        .CLK_DIV(CLK_DIV)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data     (tx_byte),
        .ps2_clk  (ser_clk),
        .ps2_data (ser_data),
        .byte_sent(frame_done)
    );

    assign bus.ps2_clk   = ser_clk;
    assign bus.ps2_data  = ser_data;
    assign bus.byte_sent = frame_done;
    assign bus.key_ready = (state_q == KbdIdle);
    assign bus.busy      = (state_q != KbdIdle);

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx with CLK_DIV=4, GAP_HALVES=4; frames are captured at ps2_clk falls.
module tb_ps2_kbd_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    ps2_kbd_tx_if bus ();

    ps2_kbd_tx #(
        .CLK_DIV   (4),
        .GAP_HALVES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Line monitor, sampled on the falling system-clock edge
    int          cyc = 0;
    logic        prev_clk = 1'b1;
    logic [10:0] cur = '0;
    int          nbits = 0;
    logic [10:0] frames[$];
    int          bs_cyc[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            nbits = 0;
        end else begin
            if (prev_clk && !bus.ps2_clk) begin
                cur[nbits] = bus.ps2_data;
                nbits = nbits + 1;
                if (nbits == 11) begin
                    frames.push_back(cur);
                    nbits = 0;
                end
            end
            if (bus.byte_sent) bs_cyc.push_back(cyc);
        end
        prev_clk = bus.ps2_clk;
    end

    // Called #1 after a posedge with the DUT idle; returns #1 after the accept edge.
    task automatic accept(input logic [7:0] code, input logic rel);
        bus.key_valid   = 1'b1;
        bus.key_code    = code;
        bus.key_release = rel;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n_ready, output int n_fall);
        n_ready = -1;
        n_fall  = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            if (n_fall < 0 && !bus.ps2_clk) n_fall = i;
            if (bus.key_ready) begin
                n_ready = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.key_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.key_ready); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_vec++; if (bus.ps2_clk !== 1'b1) begin n_err++; $display("FAIL reset_clk got %b want 1", bus.ps2_clk); end
        n_vec++; if (bus.ps2_data !== 1'b1) begin n_err++; $display("FAIL reset_data got %b want 1", bus.ps2_data); end
        n_vec++; if (bus.byte_sent !== 1'b0) begin n_err++; $display("FAIL reset_sent got %b want 0", bus.byte_sent); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_make();
        int fb, bb, nr, nf;
        fb = frames.size(); bb = bs_cyc.size();
        accept(8'h1C, 1'b0);
        n_vec++; if (bus.key_ready !== 1'b0) begin n_err++; $display("FAIL make_ready_drop got %b want 0", bus.key_ready); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL make_busy got %b want 1", bus.busy); end
        wait_idle(nr, nf);
        n_vec++; if (nf != 5) begin n_err++; $display("FAIL make_first_fall got %0d want 5", nf); end
        n_vec++; if (nr != 105) begin n_err++; $display("FAIL make_ready_latency got %0d want 105", nr); end
        n_vec++; if (frames.size() - fb != 1) begin n_err++; $display("FAIL make_nframes got %0d want 1", frames.size() - fb); end
        else begin
            n_vec++; if (frames[fb] !== 11'h438) begin n_err++; $display("FAIL make_frame got %h want 438", frames[fb]); end
        end
        n_vec++; if (bs_cyc.size() - bb != 1) begin n_err++; $display("FAIL make_nsent got %0d want 1", bs_cyc.size() - bb); end
    endtask

    task automatic test_break();
        int fb, bb, nr, nf;
        fb = frames.size(); bb = bs_cyc.size();
        accept(8'h1C, 1'b1);
        wait_idle(nr, nf);
        n_vec++; if (nr != 209) begin n_err++; $display("FAIL break_ready_latency got %0d want 209", nr); end
        n_vec++; if (frames.size() - fb != 2) begin n_err++; $display("FAIL break_nframes got %0d want 2", frames.size() - fb); end
        else begin
            n_vec++; if (frames[fb] !== 11'h7E0) begin n_err++; $display("FAIL break_frame0 got %h want 7e0", frames[fb]); end
            n_vec++; if (frames[fb+1] !== 11'h438) begin n_err++; $display("FAIL break_frame1 got %h want 438", frames[fb+1]); end
        end
        n_vec++; if (bs_cyc.size() - bb != 2) begin n_err++; $display("FAIL break_nsent got %0d want 2", bs_cyc.size() - bb); end
        else begin
            n_vec++; if (bs_cyc[bb+1] - bs_cyc[bb] != 104) begin n_err++; $display("FAIL break_spacing got %0d want 104", bs_cyc[bb+1] - bs_cyc[bb]); end
        end
    endtask

    task automatic test_parity();
        logic [7:0]  codes[3] = '{8'h00, 8'hFF, 8'h01};
        logic [10:0] want[3]  = '{11'h600, 11'h7FE, 11'h402};
        int fb, nr, nf;
        for (int k = 0; k < 3; k++) begin
            fb = frames.size();
            accept(codes[k], 1'b0);
            wait_idle(nr, nf);
            n_vec++;
            if (frames.size() - fb != 1 || frames[fb] !== want[k]) begin
                n_err++;
                $display("FAIL parity_%h got %h (frames %0d) want %h", codes[k],
                         (frames.size() > fb) ? frames[fb] : 11'h0, frames.size() - fb, want[k]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int fb, bb, nr, nf;
        fb = frames.size(); bb = bs_cyc.size();
        accept(8'h1C, 1'b0);
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h22;
        wait_idle(nr, nf);
        n_vec++; if (nr != 105) begin n_err++; $display("FAIL ignore_ready got %0d want 105", nr); end
        n_vec++; if (frames.size() - fb != 1 || bs_cyc.size() - bb != 1) begin
            n_err++; $display("FAIL ignore_first_only got frames %0d sent %0d want 1 1", frames.size() - fb, bs_cyc.size() - bb);
        end
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        n_vec++; if (bus.key_ready !== 1'b0) begin n_err++; $display("FAIL ignore_second_accept got %b want 0", bus.key_ready); end
        wait_idle(nr, nf);
        n_vec++; if (frames.size() - fb != 2) begin n_err++; $display("FAIL ignore_nframes got %0d want 2", frames.size() - fb); end
        else begin
            n_vec++; if (frames[fb] !== 11'h438) begin n_err++; $display("FAIL ignore_frame0 got %h want 438", frames[fb]); end
            n_vec++; if (frames[fb+1] !== 11'h644) begin n_err++; $display("FAIL ignore_frame1 got %h want 644", frames[fb+1]); end
        end
    endtask

    task automatic test_reset_midframe();
        int fb, bb, nr, nf;
        fb = frames.size(); bb = bs_cyc.size();
        accept(8'hFF, 1'b0);
        repeat (41) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_vec++; if (bus.ps2_clk !== 1'b1) begin n_err++; $display("FAIL rstmid_clk got %b want 1", bus.ps2_clk); end
        n_vec++; if (bus.ps2_data !== 1'b1) begin n_err++; $display("FAIL rstmid_data got %b want 1", bus.ps2_data); end
        n_vec++; if (bus.key_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", bus.key_ready); end
        repeat (150) @(posedge clk);
        #1;
        n_vec++; if (bs_cyc.size() != bb || frames.size() != fb) begin
            n_err++; $display("FAIL rstmid_aborted got sent %0d frames %0d want 0 0", bs_cyc.size() - bb, frames.size() - fb);
        end
        accept(8'h01, 1'b0);
        wait_idle(nr, nf);
        n_vec++; if (frames.size() - fb != 1 || bs_cyc.size() - bb != 1) begin
            n_err++; $display("FAIL rstmid_resume_count got frames %0d sent %0d want 1 1", frames.size() - fb, bs_cyc.size() - bb);
        end else begin
            n_vec++; if (frames[fb] !== 11'h402) begin n_err++; $display("FAIL rstmid_resume_frame got %h want 402", frames[fb]); end
        end
    endtask

`ifdef PS2_KBD_TX_EXT_EN
    task automatic test_ext();
        int fb, bb, nr, nf;
        fb = frames.size(); bb = bs_cyc.size();
        bus.key_ext = 1'b1;
        accept(8'h75, 1'b1);
        bus.key_ext = 1'b0;
        wait_idle(nr, nf);
        n_vec++; if (frames.size() - fb != 3) begin n_err++; $display("FAIL ext_nframes got %0d want 3", frames.size() - fb); end
        else begin
            n_vec++; if (frames[fb] !== 11'h5C0) begin n_err++; $display("FAIL ext_frame0 got %h want 5c0", frames[fb]); end
            n_vec++; if (frames[fb+1] !== 11'h7E0) begin n_err++; $display("FAIL ext_frame1 got %h want 7e0", frames[fb+1]); end
            n_vec++; if (frames[fb+2] !== 11'h4EA) begin n_err++; $display("FAIL ext_frame2 got %h want 4ea", frames[fb+2]); end
        end
        n_vec++; if (bs_cyc.size() - bb != 3) begin n_err++; $display("FAIL ext_nsent got %0d want 3", bs_cyc.size() - bb); end
    endtask
`endif

    initial begin
        bus.key_valid   = 1'b0;
        bus.key_code    = 8'h00;
        bus.key_release = 1'b0;
`ifdef PS2_KBD_TX_EXT_EN
        bus.key_ext     = 1'b0;
`endif
        test_reset();
        test_make();
        test_break();
        test_parity();
        test_busy_ignore();
        test_reset_midframe();
`ifdef PS2_KBD_TX_EXT_EN
        test_ext();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
